// File: rtl/pr_enc_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder family.
package pr_enc_pkg;

    localparam int PR_ENC_N_IN   = 8;
    localparam int PR_ENC_CODE_W = 3;

    typedef logic [PR_ENC_CODE_W-1:0] pr_enc_code_t;

    localparam pr_enc_code_t PR_ENC_IDLE_CODE = 3'b000;

endpackage

// File: rtl/pr_enc_8to3_comb.sv
// Combinational priority encoder: index of the highest set request bit, or idle
// with the idle code when no bit is set.
module pr_enc_8to3_comb
    import pr_enc_pkg::*;
(
    input  logic [PR_ENC_N_IN-1:0] i_req,
    output pr_enc_code_t           o_code,
    output logic                   o_idle
);

    // Ascending scan so the highest-numbered active bit is the last assignment.
    always_comb begin
        o_code = PR_ENC_IDLE_CODE;
        o_idle = 1'b1;
        for (int i = 0; i < PR_ENC_N_IN; i++) begin
            if (i_req[i]) begin
                o_code = pr_enc_code_t'(i);
                o_idle = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pr_enc_8to3.sv
// Registered 8-input priority encoder; outputs reflect the inputs sampled at
// the previous rising edge, with synchronous active-high reset to idle.
module pr_enc_8to3
    import pr_enc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic In0,
    input  logic In1,
    input  logic In2,
    input  logic In3,
    input  logic In4,
    input  logic In5,
    input  logic In6,
    input  logic In7,
    output logic Out0,
    output logic Out1,
    output logic Out2,
    output logic Idle
);

    logic [PR_ENC_N_IN-1:0] w_req;
    pr_enc_code_t           w_code;
    logic                   w_idle;
    pr_enc_code_t           r_code;
    logic                   r_idle;

    assign w_req = {In7, In6, In5, In4, In3, In2, In1, In0};

    pr_enc_8to3_comb u_comb (
        .i_req  (w_req),
        .o_code (w_code),
        .o_idle (w_idle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= PR_ENC_IDLE_CODE;
            r_idle <= 1'b1;
        end else begin
            r_code <= w_code;
            r_idle <= w_idle;
        end
    end

    assign Out0 = r_code[0];
    assign Out1 = r_code[1];
    assign Out2 = r_code[2];
    assign Idle = r_idle;

endmodule

// File: tb/tb_pr_enc_8to3.sv
// Self-checking bench for pr_enc_8to3: directed cases plus random vectors
// compared with an arithmetic "highest set bit" reference.
module tb_pr_enc_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] tb_in;
    logic       Out0, Out1, Out2, Idle;

    int n_checks;
    int n_fail;

    pr_enc_8to3 dut (
        .clk  (clk),
        .rst  (rst),
        .In0  (tb_in[0]),
        .In1  (tb_in[1]),
        .In2  (tb_in[2]),
        .In3  (tb_in[3]),
        .In4  (tb_in[4]),
        .In5  (tb_in[5]),
        .In6  (tb_in[6]),
        .In7  (tb_in[7]),
        .Out0 (Out0),
        .Out1 (Out1),
        .Out2 (Out2),
        .Idle (Idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {idle, code}; floor(log2(v)) = clog2(v+1)-1.
    function automatic logic [3:0] ref_model(input logic [7:0] v);
        int idx;
        if (v == 8'h00) return 4'b1000;
        idx = $clog2(int'(v) + 1) - 1;
        return {1'b0, 3'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got idle/code=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs and reset away from the edge, then check one cycle later.
    task automatic apply(input string tag, input logic [7:0] v, input logic r);
        logic [3:0] exp;
        @(negedge clk);
        tb_in = v;
        rst   = r;
        @(posedge clk);
        #1;
        exp = r ? 4'b1000 : ref_model(v);
        chk(tag, {Idle, Out2, Out1, Out0}, exp);
    endtask

    initial begin
        logic [7:0] v;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tb_in    = 8'hFF;

        apply("reset_c1", 8'hFF, 1'b1);
        apply("reset_c2", 8'hFF, 1'b1);
        apply("post_reset", 8'hFF, 1'b0);
        chk("post_reset_abs", {Idle, Out2, Out1, Out0}, 4'b0111);

        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            apply($sformatf("walk_%0d", i), v, 1'b0);
        end

        apply("none", 8'h00, 1'b0);
        chk("none_abs", {Idle, Out2, Out1, Out0}, 4'b1000);
        apply("in0_only", 8'h01, 1'b0);
        chk("in0_abs", {Idle, Out2, Out1, Out0}, 4'b0000);
        apply("multi_28", 8'b0010_1000, 1'b0);
        chk("multi_28_abs", {Idle, Out2, Out1, Out0}, 4'b0101);
        apply("multi_ff", 8'hFF, 1'b0);
        apply("multi_03", 8'b0000_0011, 1'b0);
        chk("multi_03_abs", {Idle, Out2, Out1, Out0}, 4'b0001);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 5; j++) apply("stream", 8'($urandom), 1'b0);
            apply("mid_reset", 8'($urandom_range(1, 255)), 1'b1);
            apply("after_reset", 8'($urandom), 1'b0);
        end

        for (int i = 0; i < 1000; i++) apply("random", 8'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
